// File: rtl/bp_cache_dma_to_axi_lite_pkg.sv
// Shared types for the bsg_cache DMA to AXI4-Lite bridge: FSM states and AXI response codes.
package bp_cache_dma_to_axi_lite_pkg;

    typedef enum logic [2:0] {
        e_idle,
        e_rd_addr,
        e_rd_data,
        e_rd_out,
        e_wr_data,
        e_wr_req,
        e_wr_resp
    } dma_state_e;

    localparam logic [1:0] axi_resp_okay_lp   = 2'b00;
    localparam logic [1:0] axi_resp_exokay_lp = 2'b01;
    localparam logic [1:0] axi_resp_slverr_lp = 2'b10;
    localparam logic [1:0] axi_resp_decerr_lp = 2'b11;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != axi_resp_okay_lp;
    endfunction

endpackage

// File: rtl/bp_cache_dma_to_axi_lite_counter.sv
// Beat counter with synchronous clear and increment, wrapping after max_val_p.
module bp_cache_dma_to_axi_lite_counter #(
    parameter int unsigned max_val_p = 7,
    parameter int unsigned width_p   = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= width_p'(up_i);
        end else if (up_i) begin
            count_o <= (count_o == width_p'(max_val_p)) ? '0 : count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bp_cache_dma_to_axi_lite.sv
// Converts bsg_cache block DMA packets into a serial stream of single-beat AXI4-Lite
// transactions, one fill word at a time, with at most one AXI transaction outstanding.
module bp_cache_dma_to_axi_lite
    import bp_cache_dma_to_axi_lite_pkg::*;
#(
    parameter int unsigned daddr_width_p    = 28,
    parameter int unsigned axi_addr_width_p = 28,
    parameter int unsigned fill_width_p     = 64,
    parameter int unsigned axi_data_width_p = 64,
    parameter int unsigned block_width_p    = 512
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,

    input  logic [daddr_width_p:0]        dma_pkt_i,
    input  logic                          dma_pkt_v_i,
    output logic                          dma_pkt_yumi_o,

    output logic [fill_width_p-1:0]       dma_data_o,
    output logic                          dma_data_v_o,
    input  logic                          dma_data_ready_and_i,

    input  logic [fill_width_p-1:0]       dma_data_i,
    input  logic                          dma_data_v_i,
    output logic                          dma_data_yumi_o,

    output logic [axi_addr_width_p-1:0]   araddr_o,
    output logic [2:0]                    arprot_o,
    output logic                          arvalid_o,
    input  logic                          arready_i,

    input  logic [axi_data_width_p-1:0]   rdata_i,
    input  logic [1:0]                    rresp_i,
    input  logic                          rvalid_i,
    output logic                          rready_o,

    output logic [axi_addr_width_p-1:0]   awaddr_o,
    output logic [2:0]                    awprot_o,
    output logic                          awvalid_o,
    input  logic                          awready_i,

    output logic [axi_data_width_p-1:0]   wdata_o,
    output logic [axi_data_width_p/8-1:0] wstrb_o,
    output logic                          wvalid_o,
    input  logic                          wready_i,

    input  logic [1:0]                    bresp_i,
    input  logic                          bvalid_i,
    output logic                          bready_o,

    output logic                          rd_error_o,
    output logic                          wr_error_o
);

    localparam int unsigned beats_lp     = block_width_p / fill_width_p;
    localparam int unsigned cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam logic [cnt_width_lp-1:0]     last_beat_lp  = cnt_width_lp'(beats_lp - 1);
    localparam logic [axi_addr_width_p-1:0] fill_bytes_lp = axi_addr_width_p'(fill_width_p / 8);

    if (fill_width_p != axi_data_width_p) begin : g_width_check
        $error("fill_width_p must equal axi_data_width_p");
    end
    if (block_width_p % fill_width_p != 0) begin : g_block_check
        $error("block_width_p must be a multiple of fill_width_p");
    end
    if (axi_addr_width_p > daddr_width_p) begin : g_addr_check
        $error("axi_addr_width_p must not exceed daddr_width_p");
    end

    dma_state_e                  state_q, state_d;
    logic [axi_addr_width_p-1:0] addr_q;
    logic [fill_width_p-1:0]     rdata_q, wdata_q;
    logic                        aw_done_q, w_done_q;
    logic                        rd_error_q, wr_error_q;
    logic [cnt_width_lp-1:0]     beat_cnt;
    logic                        cnt_clear, cnt_up;
    logic                        last_beat;

    bp_cache_dma_to_axi_lite_counter #(
        .max_val_p(beats_lp - 1),
        .width_p  (cnt_width_lp)
    ) beat_counter (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (cnt_clear),
        .up_i     (cnt_up),
        .count_o  (beat_cnt)
    );

    assign last_beat = (beat_cnt == last_beat_lp);

    // Beat address wraps naturally at the AXI address width.
    assign araddr_o   = addr_q + axi_addr_width_p'(beat_cnt) * fill_bytes_lp;
    assign awaddr_o   = araddr_o;
    assign arprot_o   = 3'b000;
    assign awprot_o   = 3'b000;
    assign wstrb_o    = '1;
    assign wdata_o    = wdata_q;
    assign dma_data_o = rdata_q;
    assign rd_error_o = rd_error_q;
    assign wr_error_o = wr_error_q;

    always_comb begin
        state_d         = state_q;
        cnt_clear       = 1'b0;
        cnt_up          = 1'b0;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_v_o    = 1'b0;
        dma_data_yumi_o = 1'b0;
        arvalid_o       = 1'b0;
        rready_o        = 1'b0;
        awvalid_o       = 1'b0;
        wvalid_o        = 1'b0;
        bready_o        = 1'b0;
        case (state_q)
            e_idle: begin
                dma_pkt_yumi_o = dma_pkt_v_i;
                if (dma_pkt_v_i) begin
                    cnt_clear = 1'b1;
                    state_d   = dma_pkt_i[daddr_width_p] ? e_wr_data : e_rd_addr;
                end
            end
            e_rd_addr: begin
                arvalid_o = 1'b1;
                if (arready_i) state_d = e_rd_data;
            end
            e_rd_data: begin
                rready_o = 1'b1;
                if (rvalid_i) state_d = e_rd_out;
            end
            e_rd_out: begin
                dma_data_v_o = 1'b1;
                if (dma_data_ready_and_i) begin
                    cnt_up  = ~last_beat;
                    state_d = last_beat ? e_idle : e_rd_addr;
                end
            end
            e_wr_data: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) state_d = e_wr_req;
            end
            e_wr_req: begin
                // AW and W handshake independently; either may finish first or both together.
                awvalid_o = ~aw_done_q;
                wvalid_o  = ~w_done_q;
                if ((aw_done_q | awready_i) & (w_done_q | wready_i)) state_d = e_wr_resp;
            end
            e_wr_resp: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    cnt_up  = ~last_beat;
                    state_d = last_beat ? e_idle : e_wr_data;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            addr_q     <= '0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rd_error_q <= 1'b0;
            wr_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == e_idle && dma_pkt_v_i) begin
                addr_q <= dma_pkt_i[axi_addr_width_p-1:0];
            end
            if (state_q == e_rd_data && rvalid_i) begin
                rdata_q <= rdata_i;
                if (resp_is_error(rresp_i)) rd_error_q <= 1'b1;
            end
            if (state_q == e_wr_data && dma_data_v_i) begin
                wdata_q   <= dma_data_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state_q == e_wr_req) begin
                if (awready_i) aw_done_q <= 1'b1;
                if (wready_i)  w_done_q  <= 1'b1;
            end
            if (state_q == e_wr_resp && bvalid_i && resp_is_error(bresp_i)) begin
                wr_error_q <= 1'b1;
            end
        end
    end

endmodule
